// File: rtl/coord_group_sched.sv
// Weight-major (weight group x activation group) issue sequencer for the sparse coordinate unit.
// Optional perf counters are built when COORD_SCHED_PERF_EN is defined.
module coord_group_sched #(
  parameter int AW    = 8,
  parameter int BASEW = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic [3:0]       i_cfg_bitwidth,
  input  logic [3:0]       i_cfg_weight_dim,
  input  logic [8:0]       i_cfg_activation_dim,
  input  logic [AW-1:0]    i_cfg_num_wgroups,
  input  logic [AW-1:0]    i_cfg_num_agroups,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err_cfg,
  output logic             o_wbuf_rd_en,
  output logic [AW-1:0]    o_wbuf_rd_addr,
  input  logic [63:0]      i_wbuf_rd_data,
  output logic             o_abuf_rd_en,
  output logic [AW-1:0]    o_abuf_rd_addr,
  input  logic [63:0]      i_abuf_rd_data,
  output logic             o_cc_valid,
  input  logic             i_cc_ready,
  output logic [3:0]       o_cc_bitwidth,
  output logic [3:0]       o_cc_weight_dim,
  output logic [8:0]       o_cc_activation_dim,
  output logic [63:0]      o_cc_weight_indices,
  output logic [63:0]      o_cc_activation_indices,
  output logic [BASEW-1:0] o_cc_weight_base,
  output logic [BASEW-1:0] o_cc_activation_base,
  output logic             o_cc_first,
  output logic             o_cc_last
`ifdef COORD_SCHED_PERF_EN
  ,
  output logic [31:0]      o_perf_issue_cnt,
  output logic [31:0]      o_perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] ONE_AW = AW'(1);

  function automatic logic bw_legal(input logic [3:0] bw);
    case (bw)
      4'b0010, 4'b0100, 4'b1000: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] bw_lanes(input logic [3:0] bw);
    case (bw)
      4'b0010: return 5'd16;
      4'b0100: return 5'd8;
      4'b1000: return 5'd4;
      default: return 5'd0;
    endcase
  endfunction

  // Distance from a group's base to its last lane index: sum of active deltas plus one per lane step.
  function automatic logic [BASEW-1:0] group_span(input logic [63:0] d, input logic [4:0] lanes);
    logic [BASEW-1:0] s;
    s = BASEW'(lanes) - BASEW'(1);
    for (int k = 0; k < 16; k++) begin
      if (5'(k) < lanes) s = s + BASEW'(d[4*k +: 4]);
      else               s = s;
    end
    return s;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_wg, r_ag, r_num_wg, r_num_ag;
  logic [BASEW-1:0]  r_weight_base, r_act_base;
  logic [3:0]        r_cc_bitwidth, r_cc_weight_dim;
  logic [8:0]        r_cc_activation_dim;
  logic [63:0]       r_cc_wi, r_cc_ai;
  logic              r_cc_first, r_cc_last;
  logic              r_busy, r_done, r_err_cfg, r_rd_en, r_cc_valid;
  logic              w_busy_nxt, w_done_nxt, w_err_nxt, w_rd_en_nxt, w_valid_nxt;
  logic              w_accept, w_hs, w_ag_end, w_wg_end, w_zero_grp;
  logic [4:0]        w_lanes;
  logic [BASEW-1:0]  w_weight_last, w_act_last;

  assign w_accept      = (r_state == S_IDLE) && i_start && bw_legal(i_cfg_bitwidth);
  assign w_zero_grp    = (i_cfg_num_wgroups == '0) || (i_cfg_num_agroups == '0);
  assign w_hs          = r_cc_valid && i_cc_ready;
  assign w_ag_end      = (r_ag == r_num_ag - ONE_AW);
  assign w_wg_end      = (r_wg == r_num_wg - ONE_AW);
  assign w_lanes       = bw_lanes(r_cc_bitwidth);
  assign w_weight_last = r_weight_base + group_span(r_cc_wi, w_lanes);
  assign w_act_last    = r_act_base + group_span(r_cc_ai, w_lanes);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_zero_grp ? S_DONE : S_FETCH;
        else          w_state_nxt = S_IDLE;
      end
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (w_hs) w_state_nxt = (w_ag_end && w_wg_end) ? S_DONE : S_FETCH;
        else      w_state_nxt = S_ISSUE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so strobes are registered and state-aligned
  always_comb begin
    w_busy_nxt  = (w_state_nxt == S_FETCH) || (w_state_nxt == S_WAIT) || (w_state_nxt == S_ISSUE);
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_rd_en_nxt = (w_state_nxt == S_FETCH);
    w_valid_nxt = (w_state_nxt == S_ISSUE);
    w_err_nxt   = (r_state == S_IDLE) && i_start && !bw_legal(i_cfg_bitwidth);
  end

  // Registered control outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err_cfg  <= 1'b0;
      r_rd_en    <= 1'b0;
      r_cc_valid <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err_cfg  <= w_err_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_cc_valid <= w_valid_nxt;
    end
  end

  // Config latch, group counters, index capture and running bases
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cc_bitwidth       <= 4'd0;
      r_cc_weight_dim     <= 4'd0;
      r_cc_activation_dim <= 9'd0;
      r_num_wg            <= '0;
      r_num_ag            <= '0;
      r_wg                <= '0;
      r_ag                <= '0;
      r_weight_base       <= '0;
      r_act_base          <= '0;
      r_cc_wi             <= 64'd0;
      r_cc_ai             <= 64'd0;
      r_cc_first          <= 1'b0;
      r_cc_last           <= 1'b0;
    end else if (w_accept) begin
      r_cc_bitwidth       <= i_cfg_bitwidth;
      r_cc_weight_dim     <= i_cfg_weight_dim;
      r_cc_activation_dim <= i_cfg_activation_dim;
      r_num_wg            <= i_cfg_num_wgroups;
      r_num_ag            <= i_cfg_num_agroups;
      r_wg                <= '0;
      r_ag                <= '0;
      r_weight_base       <= '0;
      r_act_base          <= '0;
    end else if (r_state == S_WAIT) begin
      r_cc_wi    <= i_wbuf_rd_data;
      r_cc_ai    <= i_abuf_rd_data;
      r_cc_first <= (r_ag == '0);
      r_cc_last  <= w_ag_end && w_wg_end;
    end else if ((r_state == S_ISSUE) && w_hs) begin
      if (!w_ag_end) begin
        r_ag       <= r_ag + ONE_AW;
        r_act_base <= w_act_last;
      end else if (!w_wg_end) begin
        r_wg          <= r_wg + ONE_AW;
        r_ag          <= '0;
        r_weight_base <= w_weight_last;
        r_act_base    <= '0;
      end else begin
        r_ag <= r_ag;
      end
    end else begin
      r_ag <= r_ag;
    end
  end

`ifdef COORD_SCHED_PERF_EN
  logic [31:0] r_perf_issue_cnt, r_perf_stall_cnt;

  // Handshake and backpressure counters, frozen between tiles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_issue_cnt <= 32'd0;
      r_perf_stall_cnt <= 32'd0;
    end else if (w_accept) begin
      r_perf_issue_cnt <= 32'd0;
      r_perf_stall_cnt <= 32'd0;
    end else begin
      if (w_hs) r_perf_issue_cnt <= r_perf_issue_cnt + 32'd1;
      if (r_cc_valid && !i_cc_ready) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
    end
  end

  assign o_perf_issue_cnt = r_perf_issue_cnt;
  assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

  assign o_busy                  = r_busy;
  assign o_done                  = r_done;
  assign o_err_cfg               = r_err_cfg;
  assign o_wbuf_rd_en            = r_rd_en;
  assign o_abuf_rd_en            = r_rd_en;
  assign o_wbuf_rd_addr          = r_wg;
  assign o_abuf_rd_addr          = r_ag;
  assign o_cc_valid              = r_cc_valid;
  assign o_cc_bitwidth           = r_cc_bitwidth;
  assign o_cc_weight_dim         = r_cc_weight_dim;
  assign o_cc_activation_dim     = r_cc_activation_dim;
  assign o_cc_weight_indices     = r_cc_wi;
  assign o_cc_activation_indices = r_cc_ai;
  assign o_cc_weight_base        = r_weight_base;
  assign o_cc_activation_base    = r_act_base;
  assign o_cc_first              = r_cc_first;
  assign o_cc_last               = r_cc_last;

endmodule
